// File: rtl/usb_loopback_fifo.sv
// usb_loopback_fifo: buffered loopback between the usb_cdc OUT and IN byte
// streams. Bytes are transformed on write (mode_i), stored in a FIFO, and
// released in bursts once the fill threshold is reached or the write side
// has been idle for TIMEOUT cycles.
// Optional build macro LOOPBACK_STATS_EN adds rx_bytes_o / tx_bytes_o
// handshake counters; without it those ports do not exist.
module usb_loopback_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int THRESH  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [DATA_W-1:0]        out_data_i,
  input  logic                     out_valid_i,
  output logic                     out_ready_o,
  output logic [DATA_W-1:0]        in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  input  logic [1:0]               mode_i,
  output logic [$clog2(DEPTH):0]   level_o
`ifdef LOOPBACK_STATS_EN
  ,
  output logic [15:0]              rx_bytes_o,
  output logic [15:0]              tx_bytes_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_L = PW'(THRESH);
  localparam logic [TW-1:0] TMO_L    = TW'(TIMEOUT);

  typedef enum logic {HOLD = 1'b0, BURST = 1'b1} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, level_q;
  logic [TW-1:0]     timer_q;
  state_e            state_q;
  logic [DATA_W-1:0] wdata_d;
  logic              wr_en, rd_en;

  // Handshakes and status, all derived from registered state only
  assign out_ready_o = (level_q < DEPTH_L);
  assign in_valid_o  = (state_q == BURST) && (level_q != '0);
  assign in_data_o   = in_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign level_o     = level_q;
  assign wr_en       = out_valid_i && out_ready_o;
  assign rd_en       = in_valid_o && in_ready_i;

  // Per-byte transform selected by the mode sampled with the write
  always_comb begin
    wdata_d = out_data_i;
    case (mode_i)
      2'd1:    wdata_d = ~out_data_i;
      2'd2:    wdata_d = out_data_i + 1'b1;
      2'd3: begin
        if ((out_data_i >= DATA_W'(8'h41) && out_data_i <= DATA_W'(8'h5A)) ||
            (out_data_i >= DATA_W'(8'h61) && out_data_i <= DATA_W'(8'h7A)))
          wdata_d = out_data_i ^ DATA_W'(8'h20);
      end
      default: wdata_d = out_data_i;
    endcase
  end

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_d;
  end

  // Pointers and occupancy; MSB of the pointers separates full from empty
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Idle timer: counts cycles since the last write while data is waiting
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      timer_q <= '0;
    end else if (wr_en || level_q == '0) begin
      timer_q <= '0;
    end else if (timer_q != TMO_L) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Release gate: open on threshold or idle timeout, close once drained
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= HOLD;
    end else begin
      case (state_q)
        HOLD: begin
          if (level_q >= THRESH_L || (timer_q == TMO_L && level_q != '0))
            state_q <= BURST;
        end
        BURST: begin
          if (level_q == '0) state_q <= HOLD;
        end
        default: state_q <= HOLD;
      endcase
    end
  end

`ifdef LOOPBACK_STATS_EN
  logic [15:0] rx_bytes_q, tx_bytes_q;

  // Wrapping handshake counters for link diagnostics
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rx_bytes_q <= '0;
      tx_bytes_q <= '0;
    end else begin
      if (wr_en) rx_bytes_q <= rx_bytes_q + 1'b1;
      if (rd_en) tx_bytes_q <= tx_bytes_q + 1'b1;
    end
  end

  assign rx_bytes_o = rx_bytes_q;
  assign tx_bytes_o = tx_bytes_q;
`endif

endmodule

// File: tb/tb_usb_loopback_fifo.sv
// Self-checking bench for usb_loopback_fifo: directed scenarios plus a
// randomized run, all compared every cycle against a queue-based model.
module tb_usb_loopback_fifo;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int THRESH  = 8;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready_o;
  logic [DATA_W-1:0] in_data_o;
  logic              in_valid_o;
  logic              in_ready;
  logic [1:0]        mode;
  logic [$clog2(DEPTH):0] level_o;
`ifdef LOOPBACK_STATS_EN
  logic [15:0]       rx_bytes_o, tx_bytes_o;
  logic [15:0]       rx_m, tx_m;
`endif

  usb_loopback_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .THRESH(THRESH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .out_data_i (out_data),
    .out_valid_i(out_valid),
    .out_ready_o(out_ready_o),
    .in_data_o  (in_data_o),
    .in_valid_o (in_valid_o),
    .in_ready_i (in_ready),
    .mode_i     (mode),
    .level_o    (level_o)
`ifdef LOOPBACK_STATS_EN
    ,
    .rx_bytes_o (rx_bytes_o),
    .tx_bytes_o (tx_bytes_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: stored bytes, release-gate flag, idle count
  logic [7:0] q[$];
  logic [7:0] rx_q[$];
  bit         open_m;
  int         idle_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m);
    case (m)
      2'd0: return d;
      2'd1: return ~d;
      2'd2: return d + 8'd1;
      default: begin
        if (d >= 8'h41 && d <= 8'h5A) return d + 8'h20;
        if (d >= 8'h61 && d <= 8'h7A) return d - 8'h20;
        return d;
      end
    endcase
  endfunction

  // One clock: compare at negedge, advance model at posedge
  task automatic cyc();
    bit         mr, mv, wr, rd, nopen;
    logic [7:0] md, f;
    int         nidle;
    @(negedge clk);
    mr = q.size() < DEPTH;
    mv = open_m && q.size() > 0;
    md = mv ? q[0] : 8'h00;
    chk("out_ready", out_ready_o, mr);
    chk("in_valid", in_valid_o, mv);
    chk("in_data", in_data_o, md);
    chk("level", level_o, q.size());
`ifdef LOOPBACK_STATS_EN
    chk("rx_bytes", rx_bytes_o, rx_m);
    chk("tx_bytes", tx_bytes_o, tx_m);
`endif
    if (rstn && in_valid_o && in_ready) rx_q.push_back(in_data_o);
    wr = out_valid && mr;
    rd = mv && in_ready;
    f  = xf(out_data, mode);
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      open_m = 0;
      idle_m = 0;
`ifdef LOOPBACK_STATS_EN
      rx_m = 0; tx_m = 0;
`endif
    end else begin
      if (open_m) nopen = q.size() != 0;
      else        nopen = (q.size() >= THRESH) || (idle_m == TIMEOUT && q.size() > 0);
      if (wr || q.size() == 0) nidle = 0;
      else                     nidle = (idle_m < TIMEOUT) ? idle_m + 1 : TIMEOUT;
      if (rd) q.pop_front();
      if (wr) q.push_back(f);
      open_m = nopen;
      idle_m = nidle;
`ifdef LOOPBACK_STATS_EN
      if (wr) rx_m++;
      if (rd) tx_m++;
`endif
    end
    #1;
  endtask

  task automatic drain(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin cyc(); c++; end
    chk("drain_count", rx_q.size(), n);
  endtask

  // Empty the FIFO and let the gate close before the next scenario
  task automatic settle();
    int c = 0;
    out_valid = 0; in_ready = 1;
    while (level_o != 0 && c < TIMEOUT + 4 * DEPTH) begin cyc(); c++; end
    chk("settle_empty", level_o, 0);
    cyc(); cyc();
    rx_q.delete();
  endtask

  // Returns number of cycles until in_valid_o rises, bounded
  task automatic wait_valid(output int cnt, input int budget);
    cnt = 0;
    while (!in_valid_o && cnt < budget) begin cyc(); cnt++; end
  endtask

  initial begin
    int cnt, idx;
    bit acc;
    logic [7:0] tv [4];
    logic [1:0] tm [4];
    logic [7:0] te [4];
    tv[0] = 8'h41; tv[1] = 8'h7A; tv[2] = 8'hFF; tv[3] = 8'h30;
    tm[0] = 2'd3;  tm[1] = 2'd3;  tm[2] = 2'd2;  tm[3] = 2'd1;
    te[0] = 8'h61; te[1] = 8'h5A; te[2] = 8'h00; te[3] = 8'hCF;
`ifdef LOOPBACK_STATS_EN
    rx_m = 0; tx_m = 0;
`endif
    open_m = 0; idle_m = 0;
    rstn = 0; out_valid = 0; out_data = 0; in_ready = 0; mode = 0;
    repeat (2) cyc();
    rstn = 1;
    chk("rst_level", level_o, 0);
    chk("rst_ready", out_ready_o, 1);
    chk("rst_valid", in_valid_o, 0);
    chk("rst_data", in_data_o, 0);

    // Threshold release
    in_ready = 1; mode = 0; out_valid = 1;
    for (int i = 1; i <= 8; i++) begin out_data = 8'(i); cyc(); end
    out_valid = 0;
    wait_valid(cnt, 10);
    chk("thresh_latency", cnt, 1);
    drain(8, 40);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) chk("thresh_order", rx_q[i], 8'(i + 1));
    settle();

    // Timeout release of a partial burst
    out_valid = 1;
    for (int i = 1; i <= 7; i++) begin out_data = 8'(i); cyc(); end
    out_valid = 0;
    wait_valid(cnt, TIMEOUT + 10);
    chk("timeout_latency", cnt, TIMEOUT + 1);
    drain(7, 40);
    for (int i = 0; i < 7 && i < rx_q.size(); i++) chk("timeout_order", rx_q[i], 8'(i + 1));
    settle();

    // Transforms
    out_valid = 1;
    for (int i = 0; i < 4; i++) begin out_data = tv[i]; mode = tm[i]; cyc(); end
    out_valid = 0; mode = 0;
    drain(4, TIMEOUT + 20);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("xform", rx_q[i], te[i]);
    settle();

    // Full FIFO with backpressure
    in_ready = 0; out_valid = 1; idx = 0; cnt = 0;
    while (idx < 16 && cnt < 100) begin
      out_data = 8'h41 + 8'(idx); acc = out_ready_o; cyc(); cnt++;
      if (acc) idx++;
    end
    out_data = 8'h51;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", out_ready_o, 0);
      chk("full_level", level_o, 16);
      cyc();
    end
    in_ready = 1; cnt = 0;
    while (idx < 19 && cnt < 100) begin
      out_data = 8'h41 + 8'(idx); acc = out_ready_o; cyc(); cnt++;
      if (acc) idx++;
    end
    out_valid = 0;
    drain(19, TIMEOUT + 60);
    for (int i = 0; i < 19 && i < rx_q.size(); i++) chk("full_order", rx_q[i], 8'h41 + 8'(i));
    settle();

    // Simultaneous read/write at level 5 inside a burst
    in_ready = 0; out_valid = 1;
    for (int i = 0; i < 5; i++) begin out_data = 8'h80 + 8'(i); cyc(); end
    out_valid = 0;
    wait_valid(cnt, TIMEOUT + 10);
    chk("rw_open", in_valid_o, 1);
    in_ready = 1; out_valid = 1;
    for (int i = 0; i < 10; i++) begin
      out_data = 8'h85 + 8'(i); cyc();
      chk("rw_level", level_o, 5);
    end
    out_valid = 0;
    drain(15, 40);
    for (int i = 0; i < 15 && i < rx_q.size(); i++) chk("rw_order", rx_q[i], 8'h80 + 8'(i));
    settle();

    // Reset in the middle of a burst
    in_ready = 0; out_valid = 1;
    for (int i = 0; i < 8; i++) begin out_data = 8'h10 + 8'(i); cyc(); end
    out_valid = 0;
    wait_valid(cnt, 10);
    in_ready = 1;
    repeat (4) cyc();
    chk("mid_reads", rx_q.size(), 4);
    in_ready = 0; rstn = 0; cyc(); rstn = 1;
    chk("mid_level", level_o, 0);
    chk("mid_valid", in_valid_o, 0);
    chk("mid_ready", out_ready_o, 1);
`ifdef LOOPBACK_STATS_EN
    chk("mid_rx_cnt", rx_bytes_o, 0);
    chk("mid_tx_cnt", tx_bytes_o, 0);
`endif
    rx_q.delete(); in_ready = 1;
    repeat (TIMEOUT + 5) cyc();
    chk("mid_no_leftover", rx_q.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      out_valid = ($urandom_range(0, 9) < 6);
      out_data  = 8'($urandom);
      mode      = 2'($urandom);
      in_ready  = ($urandom_range(0, 9) < ((i / 500) % 2 ? 3 : 7));
      rstn      = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rstn = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/usb_loopback_fifo.md
Name: usb_loopback_fifo

Overview:
- Parametrised loopback buffer between the usb_cdc OUT (host->device) byte stream and the IN (device->host) byte stream.
- Stores received bytes in a FIFO and applies an optional per-byte transform.
- Releases bytes in bursts, either at a fill threshold or after an idle timeout, so IN packets fill efficiently instead of going out one byte each.
- Replaces the fixed direct loopback in the Fomu example application.

Parameters:
DATA_W, 8, byte width of both streams
DEPTH, 16, FIFO entries; power of two, >= 2
THRESH, 8, fill level that opens the release gate; 1..DEPTH
TIMEOUT, 1024, idle cycles after the last write before a partial burst is released; >= 1

Ports:
clk_i  input  1  system clock (48 MHz in the Fomu build)
rstn_i  input  1  synchronous active-low reset
out_data_i  input  DATA_W  byte from usb_cdc out_data_o
out_valid_i  input  1  byte valid from usb_cdc
out_ready_o  output  1  FIFO can accept a byte
in_data_o  output  DATA_W  byte to usb_cdc in_data_i
in_valid_o  output  1  byte available to usb_cdc
in_ready_i  input  1  usb_cdc accepts the byte
mode_i  input  2  transform select, sampled at each write
level_o  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: single clock clk_i. Reset rstn_i is synchronous, active-low.
- Reset (rstn_i=0 at a clk_i edge):
  - pointers, level_o, idle timer = 0; FSM = HOLD.
  - Resulting outputs: out_ready_o=1, in_valid_o=0, in_data_o=0.
  - Reset mid-burst discards all stored bytes.
- Write:
  - occurs when out_valid_i && out_ready_o.
  - out_ready_o = (level < DEPTH), derived from registered level only.
  - The written value is f(out_data_i, mode_i):
    - 0 = pass-through
    - 1 = bitwise invert
    - 2 = +1 modulo 2^DATA_W (0xFF -> 0x00)
    - 3 = ASCII case swap: 0x41-0x5A <-> 0x61-0x7A, all other values unchanged
  - A mode_i change affects only subsequent writes.
- Read:
  - occurs when in_valid_o && in_ready_i.
  - in_data_o is the FIFO head, first-word-fall-through, valid in the same cycle in_valid_o=1.
  - in_data_o holds its value while in_valid_o=1 and in_ready_i=0.
- Pointers: width clog2(DEPTH)+1. Wrap naturally; the MSB distinguishes full from empty.
- Level update:
  - write only: +1
  - read only: -1
  - read and write in the same cycle: unchanged
  - level_o is registered.
- Idle timer:
  - cleared on every write and whenever level=0.
  - otherwise increments, saturating at TIMEOUT.
- FSM states:
  - HOLD: in_valid_o=0. Go to BURST when level >= THRESH, or when timer == TIMEOUT and level > 0.
  - BURST: in_valid_o = (level > 0). Return to HOLD in the cycle after level reaches 0. Writes during BURST are appended to the same burst.
- Latency:
  - A byte that makes level reach THRESH is presentable at in_data_o 1 cycle after the write edge (FSM transition).
  - A partial burst becomes presentable TIMEOUT+1 cycles after the last write.
- Full FIFO: out_ready_o=0 and no data is lost. A read in the full cycle frees a slot; out_ready_o returns to 1 the next cycle.
- THRESH=1: behaves as a plain registered-flag FIFO with a 1-cycle gate delay.

Optional Feature:
- Macro: LOOPBACK_STATS_EN.
- Defined: adds outputs rx_bytes_o[15:0] and tx_bytes_o[15:0].
  - They count accepted writes and reads.
  - They wrap modulo 2^16 and are cleared by rstn_i.
  - They increment in the same cycle as the handshake and are visible the next cycle.
- Not defined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Threshold release: DEPTH=16, THRESH=8, mode 0, write 0x01..0x08 back-to-back with in_ready_i=1 -> in_valid_o rises 1 cycle after the 8th write, bytes 0x01..0x08 appear in order, then HOLD.
- Timeout release: write 0x01..0x07 (below THRESH) -> no in_valid_o for TIMEOUT cycles after the last write, then 7 bytes released in order.
- Transforms: write 0x41, 0x7A, 0xFF, 0x30 with mode 3, 3, 2, 1 -> read 0x61, 0x5A, 0x00, 0xCF.
- Full/backpressure: in_ready_i=0, THRESH=16, push 19 bytes 0x41..0x53 -> 16 accepted, out_ready_o=0 for 3 beats. Release in_ready_i -> 0x41..0x50 read out, then 0x51..0x53 accepted and read out in order; level_o never exceeds 16.
- Simultaneous read/write in BURST at level=5 for 10 cycles -> level_o stays 5, order preserved, wrap past DEPTH verified.
- Reset mid-burst: after 4 of 8 bytes read, pulse rstn_i=0 for 1 cycle -> level_o=0, in_valid_o=0, out_ready_o=1, remaining bytes never appear. With LOOPBACK_STATS_EN, rx_bytes_o=tx_bytes_o=0 after reset.
